wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage: the consumer side of the MEM/WB pipeline register.
- Takes the registered MEM/WB bundle, selects the write-back data and the destination register, and writes the 8x16 architectural register file.
- Provides two combinational read ports to decode, with optional same-cycle write bypass.
- Keeps a sticky halt flag and a retired-instruction counter.

Parameters:
DATA_W, 16, register and datapath width
NREG, 8, number of architectural registers
RADDR_W, 3, register index width (log2 NREG)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
instruction_i  input  16  instruction from MEM/WB
data_read_i  input  16  memory read data from MEM/WB
address_i  input  16  ALU result from MEM/WB
pc_plus2_i  input  16  link address for JAL/JALR
RD_i  input  3  RD field from MEM/WB
RS_i  input  3  RS field from MEM/WB
Dst_reg_i  input  2  destination select
write_sel_i  input  3  write-data source select
Reg_write_i  input  1  register write request
Mem_reg_i  input  1  1 = memory data to register
halt_i  input  1  halt instruction in WB
rd_addr_a  input  3  read port A index
rd_addr_b  input  3  read port B index
rd_data_a  output  16  read port A data
rd_data_b  output  16  read port B data
wb_en_o  output  1  effective write this cycle (for forwarding)
wb_reg_o  output  3  destination index this cycle
wb_data_o  output  16  write data this cycle
halted_o  output  1  sticky halt flag
retire_cnt_o  output  16  retired instruction count

Behaviour:
Reset (rst=0, async):
- All 8 registers clear to 0.
- halted_o = 0, retire_cnt_o = 0.
- wb_en_o is forced to 0 while rst=0.

Destination select (wb_reg_o):
- Dst_reg_i 0 -> RD_i
- Dst_reg_i 1 -> RS_i
- Dst_reg_i 2 -> instruction_i[10:8]
- Dst_reg_i 3 -> 3'd7 (link register)

Write data (wb_data_o):
- If Mem_reg_i=1: data_read_i, regardless of write_sel_i.
- Otherwise, by write_sel_i:
  - 0 -> address_i
  - 1 -> data_read_i
  - 2 -> pc_plus2_i
  - 3 -> sign-extended instruction_i[7:0]
  - 4 -> {R[wb_reg_o][7:0], instruction_i[7:0]} (SLBI). Uses the pre-write contents.
  - 5..7 -> 16'h0000, and the write is suppressed.

Effective write:
- wb_en_o = rst & Reg_write_i & ~halt_i & ~halted_o & (write_sel_i<5 | Mem_reg_i).
- The register file is written at posedge when wb_en_o=1.
- Writes to R0 are legal; R0 is not hardwired.

Read ports:
- Combinational: rd_data_x = R[rd_addr_x].
- Bypass (see Optional Feature): if wb_en_o=1 and wb_reg_o==rd_addr_x, rd_data_x = wb_data_o.

Halt:
- halted_o sets at the posedge where halt_i=1 and rst=1.
- Once set it stays set until reset.
- While halted_o=1, no register writes occur and retire_cnt_o is frozen.

Retire counter:
- At posedge it increments by 1 when halted_o=0 and instruction_i != 16'h0800 (NOP).
- The halt instruction itself (16'h0000) counts once.
- Saturates at 16'hFFFF, no wrap.

Simultaneous events:
- halt_i with Reg_write_i=1: no write; the counter still increments.
- Reset asserted mid-stream: immediate clear; the first edge after release behaves as normal operation.

Latency:
- A write is architecturally visible at the edge following WB.
- With bypass, it is also visible at the read ports in the same cycle.

Optional Feature:
WB_BYPASS_EN
- Defined: read ports apply the same-cycle write bypass above, so decode sees a WB result with zero delay.
- Undefined: read ports return stored contents only, and a WB write is visible one cycle later. The hazard unit must then stall one extra cycle.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset release, no writes -> rd_data_a = rd_data_b = 0 for all 8 indices; halted_o=0; retire_cnt_o=0.
2. Reg_write_i=1, Dst_reg_i=0, RD_i=3, write_sel_i=0, address_i=16'h1234 -> R3=16'h1234 after the edge. With WB_BYPASS_EN, rd_addr_a=3 returns 16'h1234 in the same cycle; without it, the old value 0.
3. Mem_reg_i=1, write_sel_i=0, data_read_i=16'hBEEF, Dst_reg_i=3 -> R7=16'hBEEF.
4. Preload R2=16'h00AB; then SLBI: write_sel_i=4, Dst_reg_i=2, instruction_i[10:8]=2, instruction_i[7:0]=8'hCD -> R2=16'hABCD. Separately, write_sel_i=3 with imm8=8'h80 -> 16'hFF80.
5. halt_i=1 with Reg_write_i=1 to R1 -> R1 unchanged; halted_o=1 from the next cycle; retire_cnt_o advances by 1 then freezes; later Reg_write_i pulses have no effect; rst=0 clears everything.
6. Stream of 5 non-NOP instructions, 2 NOPs (16'h0800), then write_sel_i=6 with Reg_write_i=1 -> retire_cnt_o=6 (5 + the non-NOP write_sel_i=6 instruction); no register written by the write_sel_i=6 cycle.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage - write-back stage (consumer side of the MEM/WB register).
// Selects write-back data and destination, owns the 8x16 register file,
// exposes two combinational read ports, a sticky halt flag and a saturating
// retired-instruction counter.
// Optional build macro: WB_BYPASS_EN - read ports forward the same-cycle
// write-back result; when undefined they return stored contents only.
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        instruction_i,
    input  logic [DATA_W-1:0]  data_read_i,
    input  logic [DATA_W-1:0]  address_i,
    input  logic [DATA_W-1:0]  pc_plus2_i,
    input  logic [RADDR_W-1:0] RD_i,
    input  logic [RADDR_W-1:0] RS_i,
    input  logic [1:0]         Dst_reg_i,
    input  logic [2:0]         write_sel_i,
    input  logic               Reg_write_i,
    input  logic               Mem_reg_i,
    input  logic               halt_i,
    input  logic [RADDR_W-1:0] rd_addr_a,
    input  logic [RADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic [DATA_W-1:0]  rd_data_b,
    output logic               wb_en_o,
    output logic [RADDR_W-1:0] wb_reg_o,
    output logic [DATA_W-1:0]  wb_data_o,
    output logic               halted_o,
    output logic [15:0]        retire_cnt_o
);

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    logic [DATA_W-1:0]  r_regs [NREG];
    logic               r_halted;
    logic [15:0]        r_retire_cnt;

    logic [RADDR_W-1:0] w_wb_reg;
    logic [DATA_W-1:0]  w_wb_data;
    logic               w_sel_ok;
    logic               w_wb_en;

    // Destination register select.
    always_comb begin
        w_wb_reg = RD_i;
        case (Dst_reg_i)
            2'd0:    w_wb_reg = RD_i;
            2'd1:    w_wb_reg = RS_i;
            2'd2:    w_wb_reg = instruction_i[8 +: RADDR_W];
            default: w_wb_reg = {RADDR_W{1'b1}};   // link register
        endcase
    end

    // Write-data source select; SLBI reads the destination's pre-write value.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_wb_data unassigned, which would infer a latch.
        w_wb_data = '0;
        if (Mem_reg_i) begin
            w_wb_data = data_read_i;
        end else begin
            case (write_sel_i)
                3'd0:    w_wb_data = address_i;
                3'd1:    w_wb_data = data_read_i;
                3'd2:    w_wb_data = pc_plus2_i;
                3'd3:    w_wb_data = {{(DATA_W-8){instruction_i[7]}}, instruction_i[7:0]};
                3'd4:    w_wb_data = {r_regs[w_wb_reg][DATA_W-9:0], instruction_i[7:0]};
                default: w_wb_data = '0;
            endcase
        end
    end

    // Selects 5..7 are reserved and never write unless memory data is chosen.
    assign w_sel_ok  = (write_sel_i < 3'd5) | Mem_reg_i;
    assign w_wb_en   = rst & Reg_write_i & ~halt_i & ~r_halted & w_sel_ok;

    assign wb_en_o   = w_wb_en;
    assign wb_reg_o  = w_wb_reg;
    assign wb_data_o = w_wb_data;

    // Register file write port; R0 is an ordinary register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the architectural file must read zero after reset, so every entry is reset (this keeps it out of RAM macros).
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            // NOTE: non-blocking so same-edge readers (SLBI, counters) see pre-edge values.
            r_regs[w_wb_reg] <= w_wb_data;
        end
    end

    // Sticky halt flag and saturating retire counter, frozen once halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted     <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            if (!r_halted && instruction_i != NOP_INSTR && r_retire_cnt != 16'hFFFF) begin
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end
            if (halt_i) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign halted_o     = r_halted;
    assign retire_cnt_o = r_retire_cnt;

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding of the write-back result to decode.
    assign rd_data_a = (w_wb_en && w_wb_reg == rd_addr_a) ? w_wb_data : r_regs[rd_addr_a];
    assign rd_data_b = (w_wb_en && w_wb_reg == rd_addr_b) ? w_wb_data : r_regs[rd_addr_b];
`else
    // Stored contents only; a write becomes visible one cycle later.
    assign rd_data_a = r_regs[rd_addr_a];
    assign rd_data_b = r_regs[rd_addr_b];
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage - directed scenarios plus randomized stimulus for wb_stage,
// checked against a behavioural register-file / counter model.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instruction_i;
    logic [15:0] data_read_i;
    logic [15:0] address_i;
    logic [15:0] pc_plus2_i;
    logic [2:0]  RD_i;
    logic [2:0]  RS_i;
    logic [1:0]  Dst_reg_i;
    logic [2:0]  write_sel_i;
    logic        Reg_write_i;
    logic        Mem_reg_i;
    logic        halt_i;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_en_o;
    logic [2:0]  wb_reg_o;
    logic [15:0] wb_data_o;
    logic        halted_o;
    logic [15:0] retire_cnt_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_r [8];
    logic        m_halted;
    int          m_cnt;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .instruction_i(instruction_i), .data_read_i(data_read_i),
        .address_i(address_i), .pc_plus2_i(pc_plus2_i),
        .RD_i(RD_i), .RS_i(RS_i), .Dst_reg_i(Dst_reg_i),
        .write_sel_i(write_sel_i), .Reg_write_i(Reg_write_i),
        .Mem_reg_i(Mem_reg_i), .halt_i(halt_i),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_en_o(wb_en_o), .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o),
        .halted_o(halted_o), .retire_cnt_o(retire_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model, written from the architectural rules ----
    function automatic logic [2:0] m_dst();
        case (Dst_reg_i)
            2'd0:    return RD_i;
            2'd1:    return RS_i;
            2'd2:    return instruction_i[10:8];
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [15:0] m_data(input logic [2:0] d);
        logic signed [15:0] imm;
        imm = 16'($signed(instruction_i[7:0]));
        if (Mem_reg_i) return data_read_i;
        case (write_sel_i)
            3'd0:    return address_i;
            3'd1:    return data_read_i;
            3'd2:    return pc_plus2_i;
            3'd3:    return imm;
            3'd4:    return 16'((m_r[d] << 8) | {8'h00, instruction_i[7:0]});
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic m_en();
        return rst && Reg_write_i && !halt_i && !m_halted && (write_sel_i < 3'd5 || Mem_reg_i);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a, input logic [2:0] d,
                                           input logic [15:0] wd, input logic en);
`ifdef WB_BYPASS_EN
        if (en && d == a) return wd;
`endif
        return m_r[a];
    endfunction

    task automatic set_idle();
        instruction_i = 16'h0800;
        data_read_i   = 16'h0;
        address_i     = 16'h0;
        pc_plus2_i    = 16'h0;
        RD_i          = 3'd0;
        RS_i          = 3'd0;
        Dst_reg_i     = 2'd0;
        write_sel_i   = 3'd0;
        Reg_write_i   = 1'b0;
        Mem_reg_i     = 1'b0;
        halt_i        = 1'b0;
    endtask

    // Called at a negedge with inputs applied; checks outputs, crosses one posedge.
    task automatic run_cycle();
        logic [2:0]  d;
        logic [15:0] wd;
        logic        en;
        #1;
        d  = m_dst();
        wd = m_data(d);
        en = m_en();
        check("wb_en",   {31'd0, wb_en_o}, {31'd0, en});
        check("wb_reg",  {29'd0, wb_reg_o}, {29'd0, d});
        check("wb_data", {16'd0, wb_data_o}, {16'd0, wd});
        check("rd_a",    {16'd0, rd_data_a}, {16'd0, m_read(rd_addr_a, d, wd, en)});
        check("rd_b",    {16'd0, rd_data_b}, {16'd0, m_read(rd_addr_b, d, wd, en)});
        check("halted",  {31'd0, halted_o}, {31'd0, m_halted});
        check("retire",  {16'd0, retire_cnt_o}, 32'(m_cnt));
        @(posedge clk);
        if (en) m_r[d] = wd;
        if (!m_halted && instruction_i != 16'h0800 && m_cnt < 65535) m_cnt++;
        if (halt_i) m_halted = 1'b1;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting just after a negedge.
    task automatic apply_reset();
        rst = 1'b0;
        Reg_write_i = 1'b1;
        #2;
        check("rst_wb_en",  {31'd0, wb_en_o}, 32'd0);
        check("rst_halted", {31'd0, halted_o}, 32'd0);
        check("rst_retire", {16'd0, retire_cnt_o}, 32'd0);
        check("rst_rd_a",   {16'd0, rd_data_a}, 32'd0);
        check("rst_rd_b",   {16'd0, rd_data_b}, 32'd0);
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_halted = 1'b0;
        m_cnt    = 0;
        @(negedge clk);
        rst = 1'b1;
        set_idle();
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [15:0] v);
        set_idle();
        instruction_i = 16'h1000;
        RD_i = r;
        address_i = v;
        Reg_write_i = 1'b1;
        run_cycle();
        set_idle();
    endtask

    task automatic rand_inputs();
        instruction_i = ($urandom_range(0, 3) == 0) ? 16'h0800 : 16'($urandom);
        data_read_i   = 16'($urandom);
        address_i     = 16'($urandom);
        pc_plus2_i    = 16'($urandom);
        RD_i          = 3'($urandom);
        RS_i          = 3'($urandom);
        Dst_reg_i     = 2'($urandom);
        write_sel_i   = 3'($urandom);
        Reg_write_i   = ($urandom_range(0, 3) != 0);
        Mem_reg_i     = ($urandom_range(0, 4) == 0);
        halt_i        = ($urandom_range(0, 99) == 0);
        rd_addr_a     = ($urandom_range(0, 1) == 0) ? m_dst() : 3'($urandom);
        rd_addr_b     = 3'($urandom);
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        @(negedge clk);
        apply_reset();

        // 1: all registers read zero after reset, counter idle on NOPs
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            run_cycle();
        end
        check("t1_retire", {16'd0, retire_cnt_o}, 32'd0);

        // 2: ALU result to R3, same-cycle read behaviour depends on bypass
        set_idle();
        Reg_write_i = 1'b1; RD_i = 3'd3; address_i = 16'h1234; rd_addr_a = 3'd3;
        #1;
`ifdef WB_BYPASS_EN
        check("t2_bypass", {16'd0, rd_data_a}, 32'h1234);
`else
        check("t2_nobypass", {16'd0, rd_data_a}, 32'h0000);
`endif
        run_cycle();
        set_idle();
        #1 check("t2_r3", {16'd0, rd_data_a}, 32'h1234);
        run_cycle();

        // 3: memory data to link register overrides write_sel
        set_idle();
        Mem_reg_i = 1'b1; Reg_write_i = 1'b1; data_read_i = 16'hBEEF;
        Dst_reg_i = 2'd3; write_sel_i = 3'd6;
        run_cycle();
        set_idle();
        rd_addr_b = 3'd7;
        #1 check("t3_r7", {16'd0, rd_data_b}, 32'hBEEF);
        run_cycle();

        // 4: SLBI on R2 and sign-extended immediate
        write_reg(3'd2, 16'h00AB);
        Reg_write_i = 1'b1; write_sel_i = 3'd4; Dst_reg_i = 2'd2; instruction_i = 16'h02CD;
        #1 check("t4_slbi", {16'd0, wb_data_o}, 32'hABCD);
        run_cycle();
        set_idle();
        rd_addr_a = 3'd2;
        #1 check("t4_r2", {16'd0, rd_data_a}, 32'hABCD);
        Reg_write_i = 1'b1; write_sel_i = 3'd3; RD_i = 3'd4; instruction_i = 16'h0080;
        #1 check("t4_sext", {16'd0, wb_data_o}, 32'hFF80);
        run_cycle();

        // 6: retire count over a mixed stream
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            set_idle();
            instruction_i = (i < 5) ? 16'(16'h1100 + i) : 16'h0800;
            run_cycle();
        end
        set_idle();
        instruction_i = 16'h4321; write_sel_i = 3'd6; Reg_write_i = 1'b1; RD_i = 3'd5;
        #1 check("t6_en", {31'd0, wb_en_o}, 32'd0);
        run_cycle();
        set_idle();
        rd_addr_a = 3'd5;
        #1 check("t6_retire", {16'd0, retire_cnt_o}, 32'd6);
        check("t6_r5", {16'd0, rd_data_a}, 32'd0);

        // 5: halt with a write request, then frozen state
        write_reg(3'd1, 16'h5555);
        Reg_write_i = 1'b1; RD_i = 3'd1; address_i = 16'h9999; halt_i = 1'b1;
        instruction_i = 16'h0000;
        run_cycle();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            instruction_i = 16'h2222; Reg_write_i = 1'b1; RD_i = 3'd1; address_i = 16'h7777;
            rd_addr_a = 3'd1;
            run_cycle();
        end
        #1;
        check("t5_halted", {31'd0, halted_o}, 32'd1);
        check("t5_r1",     {16'd0, rd_data_a}, 32'h5555);
        check("t5_retire", {16'd0, retire_cnt_o}, 32'd8);
        apply_reset();

        // random phase with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) apply_reset();
            else run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
